addsub_arbiter: RTL

//   Shares one 14-bit combinational add/subtract unit between N_REQ requesters.

---
 rtl/addsub_arbiter.sv | 117 +++++++++++
 1 files changed

// File: rtl/addsub_arbiter.sv
// Round-robin arbiter sharing one combinational add/subtract unit between N_REQ requesters.
// Registers the winner's operands toward the unit, captures its result and returns it with the winner's ID.
module addsub_arbiter #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 14,
  parameter int ID_W  = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*WIDTH-1:0] a_bus,
  input  logic [N_REQ*WIDTH-1:0] b_bus,
  input  logic [N_REQ-1:0]       oper_bus,
  output logic [N_REQ-1:0]       gnt,
  output logic [WIDTH-1:0]       au_a,
  output logic [WIDTH-1:0]       au_b,
  output logic                   au_oper,
  input  logic [WIDTH-1:0]       au_c,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [WIDTH-1:0]       res_data,
  output logic [ID_W-1:0]        res_id,
  output logic                   busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state, state_nxt;
  logic [ID_W-1:0] rr_ptr;
  logic [ID_W-1:0] win_id;
  logic [ID_W-1:0] winner;

  logic [WIDTH-1:0] a_arr [N_REQ];
  logic [WIDTH-1:0] b_arr [N_REQ];

  for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
    assign a_arr[i] = a_bus[i*WIDTH +: WIDTH];
    assign b_arr[i] = b_bus[i*WIDTH +: WIDTH];
  end

  // Scanning offsets from farthest to nearest lets the closest asserted request overwrite the others.
  function automatic logic [ID_W-1:0] pick(input logic [N_REQ-1:0] r,
                                           input logic [ID_W-1:0]  ptr);
    logic [ID_W-1:0] sel;
    int              idx;
    sel = ptr;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      idx = (int'(ptr) + k) % N_REQ;
      if (r[ID_W'(idx)]) sel = ID_W'(idx);
    end
    return sel;
  endfunction

  assign winner = pick(req, rr_ptr);
  assign busy   = (state != IDLE);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // NOTE: the default assignment first keeps this block purely combinational (no inferred latch).
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (|req) state_nxt = EXEC;
      EXEC:    state_nxt = DONE;
      DONE:    if (res_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr    <= '0;
      win_id    <= '0;
      gnt       <= '0;
      au_a      <= '0;
      au_b      <= '0;
      au_oper   <= 1'b0;
      res_valid <= 1'b0;
      res_data  <= '0;
      res_id    <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (|req) begin
            au_a    <= a_arr[winner];
            au_b    <= b_arr[winner];
            au_oper <= oper_bus[winner];
            gnt     <= N_REQ'(1) << winner;
            win_id  <= winner;
          end
        end
        EXEC: begin
          res_data  <= au_c;
          res_id    <= win_id;
          res_valid <= 1'b1;
          gnt       <= '0;
        end
        DONE: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            rr_ptr    <= (win_id == ID_W'(N_REQ - 1)) ? '0 : win_id + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
